dm_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface.
- Accepts one word-sized request at a time over a req/ack handshake and inserts a programmable number of wait states.
- Completes writes with byte enables or returns read data, and flags illegal accesses.
- Sits between the datapath's memory-access stage and an internal word array; replaces the zero-latency data memory once the core moves to a stalling memory interface.

---
 rtl/dm_responder_if.sv | 23 ++
 rtl/dm_responder.sv | 114 +++++++++++
 tb/tb_dm_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Load/store request and response bundle between the
// memory-access stage and the data-memory responder.
interface dm_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;

   modport master (
      output req, we, addr, wdata, be,
      input  ack, rdata, err, busy
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ack, rdata, err, busy
   );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one word access at a time,
// programmable wait states, byte-enabled writes, illegal-access flag.
module dm_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic          clk,
   input  logic          reset,
   dm_responder_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        h_we;
   logic [31:0] h_addr;
   logic [31:0] h_wdata;
   logic [3:0]  h_be;

   logic [31:0] mem [DEPTH];

   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic                  in_idle;
   logic                  s_we;
   logic [31:0]           s_addr;
   logic                  s_err;
   logic                  h_err;
   logic [ADDR_WIDTH-1:0] s_idx;
   logic [ADDR_WIDTH-1:0] h_idx;
   logic                  go_resp;

   function automatic logic illegal(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != '0);
   endfunction

   // Response is formed on the edge entering RESP; with no wait
   // states that edge is also the capture edge, so use live inputs.
   assign in_idle = (state == IDLE);
   assign s_we    = in_idle ? bus.we   : h_we;
   assign s_addr  = in_idle ? bus.addr : h_addr;
   assign s_err   = illegal(s_addr);
   assign h_err   = illegal(h_addr);
   assign s_idx   = s_addr[ADDR_WIDTH+1:2];
   assign h_idx   = h_addr[ADDR_WIDTH+1:2];

   assign go_resp = (in_idle && bus.req && (WAIT_STATES == 0))
                 || ((state == BUSY) && (cnt == 4'd0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         h_we    <= 1'b0;
         h_addr  <= '0;
         h_wdata <= '0;
         h_be    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= go_resp;
         err_q   <= go_resp && s_err;
         rdata_q <= (go_resp && !s_err && !s_we) ? mem[s_idx] : '0;
         unique case (state)
            IDLE: begin
               if (bus.req) begin
                  h_we    <= bus.we;
                  h_addr  <= bus.addr;
                  h_wdata <= bus.wdata;
                  h_be    <= bus.be;
                  if (WAIT_STATES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Writes land at the end of RESP, so a reset in BUSY drops them.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if ((state == RESP) && h_we && !h_err) begin
         for (int b = 0; b < 4; b++) begin
            if (h_be[b]) mem[h_idx][8*b +: 8] <= h_wdata[8*b +: 8];
         end
      end
   end

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = !in_idle;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: vector table through a scoreboard on a
// two-wait-state instance, plus hand sequences for corner cases.
module tb_dm_responder;
   localparam int WS0 = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_responder_if bus0 ();
   dm_responder_if bus1 ();

   dm_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS0)) u0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   dm_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   vec_t vecs[17];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic txn(input vec_t v);
      exp_t e;
      int   n;
      @(negedge clk);
      bus0.req   = 1'b1;
      bus0.we    = v.we;
      bus0.addr  = v.addr;
      bus0.wdata = v.wdata;
      bus0.be    = v.be;
      sb.push_back('{v.err, v.rdata});
      @(posedge clk);
      @(negedge clk);
      // scramble live inputs: only the captured copy may matter
      bus0.req   = 1'b0;
      bus0.we    = ~v.we;
      bus0.addr  = 32'h0000_0002;
      bus0.wdata = 32'hFFFF_FFFF;
      bus0.be    = 4'hF;
      n = 1;
      while (!bus0.ack && n < WS0 + 6) begin
         @(negedge clk);
         n++;
      end
      chk("ack_seen", 32'(bus0.ack), 32'd1);
      e = sb.pop_front();
      if (bus0.ack) begin
         chk("latency", 32'(n), 32'(WS0 + 1));
         chk("err", 32'(bus0.err), 32'(e.err));
         chk("rdata", bus0.rdata, e.rdata);
      end
      @(negedge clk);
      chk("ack_pulse", 32'(bus0.ack), 32'd0);
      chk("idle_busy", 32'(bus0.busy), 32'd0);
      chk("idle_rdata", bus0.rdata, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h1, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 1'b0, 32'h11BB33DD};
      vecs[5]  = '{1'b1, 32'h22,   32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 1'b0, 32'h11BB33DD};
      vecs[7]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 32'h13,   32'h0,        4'h0, 1'b1, 32'h0};
      vecs[9]  = '{1'b1, 32'h30,   32'h55,       4'hF, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h30,   32'h0,        4'h0, 1'b0, 32'h55};
      vecs[11] = '{1'b1, 32'h44,   32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 32'h44,   32'h0,        4'h0, 1'b0, 32'h0};
      vecs[13] = '{1'b1, 32'hFFC,  32'h12345678, 4'h8, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 1'b0, 32'h12000000};
      vecs[15] = '{1'b1, 32'h80000000, 32'h1,    4'hF, 1'b1, 32'h0};
      vecs[16] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0};

      reset = 1'b1;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0;
      bus0.wdata = '0; bus0.be = '0;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0;
      bus1.wdata = '0; bus1.be = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_ack", 32'(bus0.ack), 32'd0);
      chk("rst_err", 32'(bus0.err), 32'd0);
      chk("rst_rdata", bus0.rdata, 32'd0);
      chk("rst_busy", 32'(bus0.busy), 32'd0);

      for (int i = 0; i < 17; i++) txn(vecs[i]);

      // reset while a write to 0x40 sits in BUSY
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h40;
      bus0.wdata = 32'h12345678; bus0.be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("busy_mid", 32'(bus0.busy), 32'd1);
      bus0.req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy_ack", 32'(bus0.ack), 32'd0);
      chk("rst_busy_busy", 32'(bus0.busy), 32'd0);
      txn('{1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0});
      txn('{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0});

      // zero-wait instance: req held, write then back-to-back reads
      @(negedge clk);
      bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h0;
      bus1.wdata = 32'hCAFEF00D; bus1.be = 4'hF;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) bus1.we = 1'b0;
         chk("ws0_busy", 32'(bus1.busy), 32'(i % 2));
         chk("ws0_ack", 32'(bus1.ack), 32'(i % 2));
         chk("ws0_err", 32'(bus1.err), 32'd0);
         chk("ws0_rdata", bus1.rdata,
             (i % 2 == 1 && i > 1) ? 32'hCAFEF00D : 32'h0);
      end
      bus1.req = 1'b0;
      repeat (3) @(negedge clk);
      chk("ws0_idle", 32'(bus1.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
